serial_arbiter: RTL and testbench

//  Shares one 32-bit valid/ready serial link to the target (host-to-target + target-to-host) among
//  N_CLIENTS requesters. Grants whole request packets round-robin, locks until the last word,
//  and routes each response packet back to its requester in order via a tag FIFO.

---
 rtl/serial_arb_pkg.sv | 24 ++
 rtl/serial_tag_fifo.sv | 63 ++++++
 rtl/serial_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_serial_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | serial_arb_pkg : header field positions and FSM state types for the arbiter |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
package serial_arb_pkg;

   localparam int HDR_LEN_LSB = 0;
   localparam int HDR_LEN_MSB = 15;
   localparam int HDR_EXP_BIT = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } req_state_t;

   typedef enum logic [0:0] {
      R_HDR  = 1'b0,
      R_BODY = 1'b1
   } rsp_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_tag_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | serial_tag_fifo : synchronous FIFO of requester tags, async-reset clear     |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module serial_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rd_data = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | serial_arbiter : round-robin packet arbiter for a shared valid/ready link,  |
// |                  with in-order response routing through a tag FIFO         |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module serial_arbiter
   import serial_arb_pkg::*;
#(
   parameter int N_CLIENTS = 2,
   parameter int W         = 32,
   parameter int TAG_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CLIENTS-1:0]   i_req_valid,
   output logic [N_CLIENTS-1:0]   o_req_ready,
   input  logic [N_CLIENTS*W-1:0] i_req_bits,
   output logic [N_CLIENTS-1:0]   o_rsp_valid,
   input  logic [N_CLIENTS-1:0]   i_rsp_ready,
   output logic [W-1:0]           o_rsp_bits,
   output logic                   o_serial_in_valid,
   input  logic                   i_serial_in_ready,
   output logic [W-1:0]           o_serial_in_bits,
   input  logic                   i_serial_out_valid,
   output logic                   o_serial_out_ready,
   input  logic [W-1:0]           i_serial_out_bits,
   output logic                   o_orphan_err
);

   localparam int TW = $clog2(N_CLIENTS);

   req_state_t     r_req_state;
   rsp_state_t     r_rsp_state;
   logic [TW-1:0]  r_grant;
   logic [TW-1:0]  r_rr_ptr;
   logic [15:0]    r_cnt;
   logic [15:0]    r_rcnt;
   logic           r_orphan;

   logic [W-1:0]   w_req_word [N_CLIENTS];
   logic [W-1:0]   w_word;
   logic           w_active;
   logic           w_block;
   logic           w_in_fire;
   logic           w_out_fire;
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic [TW-1:0]  w_dest;
   logic [TW-1:0]  w_pick;
   logic           w_pick_found;
   logic [TW-1:0]  w_next_ptr;

   for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
      assign w_req_word[gi] = i_req_bits[gi*W +: W];
   end

   assign w_word     = w_req_word[r_grant];
   assign w_active   = (r_req_state != IDLE);
   // A response-expecting header waits for a free tag slot; the registered
   // full flag means a pop only unblocks on the following cycle.
   assign w_block    = (r_req_state == HDR) && w_word[HDR_EXP_BIT] && w_full;
   assign w_next_ptr = (r_grant == TW'(N_CLIENTS - 1)) ? '0 : r_grant + 1'b1;

   always_comb begin
      o_req_ready       = '0;
      o_serial_in_valid = w_active && !w_block && i_req_valid[r_grant];
      o_serial_in_bits  = w_word;
      if (w_active && !w_block) begin
         o_req_ready[r_grant] = i_serial_in_ready;
      end
   end

   assign w_in_fire = o_serial_in_valid && i_serial_in_ready;
   assign w_push    = (r_req_state == HDR) && w_in_fire && w_word[HDR_EXP_BIT];

   always_comb begin
      int idx;
      w_pick_found = 1'b0;
      w_pick       = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_CLIENTS) begin
            idx = idx - N_CLIENTS;
         end
         if (!w_pick_found && i_req_valid[TW'(idx)]) begin
            w_pick_found = 1'b1;
            w_pick       = TW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_state <= IDLE;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_req_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_grant     <= w_pick;
                  r_req_state <= HDR;
               end
            end
            HDR: begin
               if (w_in_fire) begin
                  r_cnt <= w_word[HDR_LEN_MSB:HDR_LEN_LSB];
                  if (w_word[HDR_LEN_MSB:HDR_LEN_LSB] == 16'd0) begin
                     r_req_state <= IDLE;
                     r_rr_ptr    <= w_next_ptr;
                  end else begin
                     r_req_state <= BODY;
                  end
               end
            end
            BODY: begin
               if (w_in_fire) begin
                  r_cnt <= r_cnt - 16'd1;
                  if (r_cnt == 16'd1) begin
                     r_req_state <= IDLE;
                     r_rr_ptr    <= w_next_ptr;
                  end
               end
            end
            default: r_req_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      o_rsp_valid        = '0;
      o_serial_out_ready = 1'b0;
      o_rsp_bits         = i_serial_out_bits;
      if (!w_empty) begin
         o_rsp_valid[w_dest] = i_serial_out_valid;
         o_serial_out_ready  = i_rsp_ready[w_dest];
      end
   end

   assign w_out_fire = i_serial_out_valid && o_serial_out_ready;
   assign w_pop      = w_out_fire &&
                       (((r_rsp_state == R_HDR) && (i_serial_out_bits[HDR_LEN_MSB:HDR_LEN_LSB] == 16'd0)) ||
                        ((r_rsp_state == R_BODY) && (r_rcnt == 16'd1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_state <= R_HDR;
         r_rcnt      <= '0;
         r_orphan    <= 1'b0;
      end else begin
         if ((r_rsp_state == R_HDR) && w_empty && i_serial_out_valid) begin
            r_orphan <= 1'b1;
         end
         if (w_out_fire) begin
            if (r_rsp_state == R_HDR) begin
               r_rcnt <= i_serial_out_bits[HDR_LEN_MSB:HDR_LEN_LSB];
               if (i_serial_out_bits[HDR_LEN_MSB:HDR_LEN_LSB] != 16'd0) begin
                  r_rsp_state <= R_BODY;
               end
            end else begin
               r_rcnt <= r_rcnt - 16'd1;
               if (r_rcnt == 16'd1) begin
                  r_rsp_state <= R_HDR;
               end
            end
         end
      end
   end

   assign o_orphan_err = r_orphan;

   serial_tag_fifo #(
      .WIDTH (TW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_wr_data (r_grant),
      .i_pop     (w_pop),
      .o_rd_data (w_dest),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_serial_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_serial_arbiter : directed vector table plus hand-written corner cases    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_serial_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  i_req_valid = '0;
   logic [1:0]  o_req_ready;
   logic [63:0] i_req_bits = '0;
   logic [1:0]  o_rsp_valid;
   logic [1:0]  i_rsp_ready = '0;
   logic [31:0] o_rsp_bits;
   logic        o_serial_in_valid;
   logic        i_serial_in_ready = 1'b1;
   logic [31:0] o_serial_in_bits;
   logic        i_serial_out_valid = 1'b0;
   logic        o_serial_out_ready;
   logic [31:0] i_serial_out_bits = '0;
   logic        o_orphan_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_arbiter #(.N_CLIENTS(2), .W(32), .TAG_DEPTH(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_bits         (i_req_bits),
      .o_rsp_valid        (o_rsp_valid),
      .i_rsp_ready        (i_rsp_ready),
      .o_rsp_bits         (o_rsp_bits),
      .o_serial_in_valid  (o_serial_in_valid),
      .i_serial_in_ready  (i_serial_in_ready),
      .o_serial_in_bits   (o_serial_in_bits),
      .i_serial_out_valid (i_serial_out_valid),
      .o_serial_out_ready (o_serial_out_ready),
      .i_serial_out_bits  (i_serial_out_bits),
      .o_orphan_err       (o_orphan_err)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  rv;
      logic [31:0] b0;
      logic [31:0] b1;
      logic        sir;
      logic        sov;
      logic [31:0] sob;
      logic [1:0]  rr;
      logic        siv_e;
      logic [31:0] sib_e;
      logic [1:0]  rqr_e;
      logic [1:0]  rsv_e;
      logic        sor_e;
      logic        orph_e;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic r, input logic [1:0] rv, input logic [31:0] b0,
                              input logic [31:0] b1, input logic sir, input logic sov,
                              input logic [31:0] sob, input logic [1:0] rr, input logic siv_e,
                              input logic [31:0] sib_e, input logic [1:0] rqr_e,
                              input logic [1:0] rsv_e, input logic sor_e, input logic orph_e);
      vec_t t;
      t.rst = r;   t.rv = rv;   t.b0 = b0;   t.b1 = b1;   t.sir = sir;
      t.sov = sov; t.sob = sob; t.rr = rr;   t.siv_e = siv_e;
      t.sib_e = sib_e; t.rqr_e = rqr_e; t.rsv_e = rsv_e; t.sor_e = sor_e; t.orph_e = orph_e;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req_valid = '0;
      i_serial_out_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Drives one packet from client c (header then nbody payload words) to completion.
   task automatic send_pkt(input int c, input logic [31:0] hdr, input int nbody);
      int sent  = 0;
      int guard = 0;
      logic [31:0] word;
      while (sent <= nbody && guard < 100) begin
         word = (sent == 0) ? hdr : (32'hD000_0000 | (c << 16) | sent);
         i_req_valid = '0;
         i_req_valid[c] = 1'b1;
         i_req_bits[c*32 +: 32] = word;
         #1;
         if (o_req_ready[c] && o_serial_in_valid) begin
            check($sformatf("send_c%0d_w%0d", c, sent), {32'h0, o_serial_in_bits}, {32'h0, word});
            sent++;
         end
         tick();
         guard++;
      end
      if (sent <= nbody) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: client %0d sent %0d words, required %0d", c, sent, nbody + 1);
      end
      i_req_valid = '0;
   endtask

   initial begin
      logic [63:0] act;
      logic [63:0] exp;

      // rst rv  b0            b1            sir sov sob           rr    siv sib           rqr   rsv   sor orph
      vecs.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h8000_0002, 32'h0,       1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h8000_0002, 32'h0,       1, 0, 32'h0,        2'b00, 1, 32'h8000_0002, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h1111_0001, 32'h0,       1, 0, 32'h0,        2'b00, 1, 32'h1111_0001, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h1111_0002, 32'h0,       1, 0, 32'h0,        2'b00, 1, 32'h1111_0002, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h0000_0001, 2'b01, 0, 32'h0,        2'b00, 2'b01, 1, 0));
      vecs.push_back(v(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h2222_0001, 2'b00, 0, 32'h0,        2'b00, 2'b01, 0, 0));
      vecs.push_back(v(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h2222_0001, 2'b01, 0, 32'h0,        2'b00, 2'b01, 1, 0));
      vecs.push_back(v(0, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(1, 2'b11, 32'h3,        32'h3,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h3,        32'h3,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h3,        32'h3,        1, 0, 32'h0,        2'b00, 1, 32'h3,        2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0A00_0001, 32'h3,       0, 0, 32'h0,        2'b00, 1, 32'h0A00_0001, 2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0A00_0001, 32'h3,       1, 0, 32'h0,        2'b00, 1, 32'h0A00_0001, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0A00_0002, 32'h3,       1, 0, 32'h0,        2'b00, 1, 32'h0A00_0002, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0A00_0003, 32'h3,       1, 0, 32'h0,        2'b00, 1, 32'h0A00_0003, 2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0,        32'h3,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0,        32'h3,        1, 0, 32'h0,        2'b00, 1, 32'h3,        2'b10, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0,        32'h0B00_0001, 1, 0, 32'h0,       2'b00, 1, 32'h0B00_0001, 2'b10, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0,        32'h0B00_0002, 1, 0, 32'h0,       2'b00, 1, 32'h0B00_0002, 2'b10, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 32'h0,        32'h0B00_0003, 1, 0, 32'h0,       2'b00, 1, 32'h0B00_0003, 2'b10, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h0,        32'h0,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 32'h0,        32'h0,        1, 0, 32'h0,        2'b00, 1, 32'h0,        2'b01, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0,        2'b00, 0, 32'h0,        2'b00, 2'b00, 0, 0));

      @(negedge clk);
      foreach (vecs[i]) begin
         rst                = vecs[i].rst;
         i_req_valid        = vecs[i].rv;
         i_req_bits         = {vecs[i].b1, vecs[i].b0};
         i_serial_in_ready  = vecs[i].sir;
         i_serial_out_valid = vecs[i].sov;
         i_serial_out_bits  = vecs[i].sob;
         i_rsp_ready        = vecs[i].rr;
         #1;
         act = {25'h0, o_serial_in_valid, (o_serial_in_valid ? o_serial_in_bits : 32'h0),
                o_req_ready, o_rsp_valid, o_serial_out_ready, o_orphan_err};
         exp = {25'h0, vecs[i].siv_e, vecs[i].sib_e, vecs[i].rqr_e, vecs[i].rsv_e,
                vecs[i].sor_e, vecs[i].orph_e};
         check($sformatf("vec%0d", i), act, exp);
         if (vecs[i].rsv_e != 2'b00) begin
            check($sformatf("vec%0d_rsp_bits", i), {32'h0, o_rsp_bits}, {32'h0, vecs[i].sob});
         end
         tick();
      end

      // Tag FIFO full: fifth response-expecting header stalls until the cycle after a pop.
      do_reset();
      i_serial_in_ready = 1'b1;
      i_rsp_ready = 2'b00;
      for (int k = 0; k < 4; k++) begin
         send_pkt(0, 32'h8000_0000, 0);
      end
      i_req_valid = 2'b01;
      i_req_bits[31:0] = 32'h8000_0000;
      #1 check("t3_bubble", {63'h0, o_serial_in_valid}, 64'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("t3_stall%0d", k), {61'h0, o_serial_in_valid, o_req_ready}, 64'h0);
         tick();
      end
      i_serial_out_valid = 1'b1;
      i_serial_out_bits  = 32'h0000_0000;
      i_rsp_ready        = 2'b01;
      #1;
      check("t3_pop_rsp", {61'h0, o_rsp_valid, o_serial_out_ready}, {61'h0, 2'b01, 1'b1});
      check("t3_same_cycle", {61'h0, o_serial_in_valid, o_req_ready}, 64'h0);
      tick();
      i_serial_out_valid = 1'b0;
      #1 check("t3_issue", {29'h0, o_serial_in_valid, o_serial_in_bits, o_req_ready},
               {29'h0, 1'b1, 32'h8000_0000, 2'b01});
      tick();
      i_req_valid = '0;

      // Responses return in request order: client 1 first, then client 0.
      do_reset();
      i_rsp_ready = 2'b11;
      send_pkt(1, 32'h8000_0001, 1);
      send_pkt(0, 32'h8000_0000, 0);
      i_serial_out_valid = 1'b1;
      i_serial_out_bits  = 32'h0000_0000;
      #1 check("t4_dest1", {29'h0, o_rsp_valid, o_serial_out_ready, o_rsp_bits},
               {29'h0, 2'b10, 1'b1, 32'h0});
      tick();
      i_serial_out_bits = 32'h0000_0001;
      #1 check("t4_dest0_hdr", {62'h0, o_rsp_valid}, {62'h0, 2'b01});
      tick();
      i_serial_out_bits = 32'h3333_0001;
      #1 check("t4_dest0_body", {30'h0, o_rsp_valid, o_rsp_bits}, {30'h0, 2'b01, 32'h3333_0001});
      tick();
      i_serial_out_valid = 1'b0;

      // Orphan response header with no outstanding tag.
      i_serial_out_valid = 1'b1;
      i_serial_out_bits  = 32'h0000_0002;
      #1 check("t5_stall", {60'h0, o_serial_out_ready, o_rsp_valid, o_orphan_err}, 64'h0);
      tick();
      #1 check("t5_orphan_set", {63'h0, o_orphan_err}, 64'h1);
      i_serial_out_valid = 1'b0;
      tick();
      tick();
      #1 check("t5_sticky", {63'h0, o_orphan_err}, 64'h1);
      tick();

      // Reset in the middle of a packet body (five words still to go).
      i_req_valid = 2'b01;
      i_req_bits[31:0] = 32'h0000_0008;
      tick();
      #1 check("t6_hdr", {63'h0, o_serial_in_valid}, 64'h1);
      tick();
      for (int k = 1; k <= 3; k++) begin
         i_req_bits[31:0] = 32'hE000_0000 | k;
         #1 check($sformatf("t6_body%0d", k), {62'h0, o_req_ready}, {62'h0, 2'b01});
         tick();
      end
      rst = 1'b1;
      #1 check("t6_reset_outputs",
               {57'h0, o_serial_in_valid, o_req_ready, o_rsp_valid, o_serial_out_ready, o_orphan_err},
               64'h0);
      tick();
      rst = 1'b0;
      i_req_valid = 2'b10;
      i_req_bits  = 64'h0;
      #1 check("t6_idle", {63'h0, o_serial_in_valid}, 64'h0);
      tick();
      #1 check("t6_fresh_hdr", {29'h0, o_serial_in_valid, o_serial_in_bits, o_req_ready},
               {29'h0, 1'b1, 32'h0, 2'b10});
      tick();
      i_req_valid = '0;
      #1 check("t6_done", {63'h0, o_serial_in_valid}, 64'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
